alu_op_issuer: RTL and testbench

- Initiator side of the datapath ALU interface. Drives BusA/BusB/ALUCtrl into the combinational ALU and captures BusW/Zero.
- Accepts one operation at a time from upstream over a valid/ready handshake.
- Encodes MOVZ operands into the BusA bit layout the ALU decodes.
- Holds ALU inputs stable for a programmable settle window, registers the result, and returns it downstream over a second valid/ready handshake.

---
 rtl/alu_op_issuer_if.sv | 48 ++++
 rtl/alu_op_issuer.sv | 145 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issuer_if.sv
// Request/ALU/response bundle for alu_op_issuer; RespOvf exists only with ALU_ISSUER_OVF_EN.
// master = upstream/ALU/downstream environment, slave = the issuer.
interface alu_op_issuer_if #(
    parameter int TAG_W = 4
);
    logic             ReqValid;
    logic             ReqReady;
    logic [2:0]       ReqOp;
    logic [63:0]      ReqA;
    logic [63:0]      ReqB;
    logic [15:0]      ReqImm16;
    logic [1:0]       ReqHw;
    logic [TAG_W-1:0] ReqTag;
    logic [63:0]      AluBusA;
    logic [63:0]      AluBusB;
    logic [3:0]       AluCtrl;
    logic [63:0]      AluBusW;
    logic             AluZero;
    logic             RespValid;
    logic             RespReady;
    logic [63:0]      RespData;
    logic             RespZero;
    logic [TAG_W-1:0] RespTag;
    logic             RespErr;
`ifdef ALU_ISSUER_OVF_EN
    logic             RespOvf;

    modport master (
        output ReqValid, ReqOp, ReqA, ReqB, ReqImm16, ReqHw, ReqTag, AluBusW, AluZero, RespReady,
        input  ReqReady, AluBusA, AluBusB, AluCtrl, RespValid, RespData, RespZero, RespTag, RespErr,
               RespOvf
    );
    modport slave (
        input  ReqValid, ReqOp, ReqA, ReqB, ReqImm16, ReqHw, ReqTag, AluBusW, AluZero, RespReady,
        output ReqReady, AluBusA, AluBusB, AluCtrl, RespValid, RespData, RespZero, RespTag, RespErr,
               RespOvf
    );
`else
    modport master (
        output ReqValid, ReqOp, ReqA, ReqB, ReqImm16, ReqHw, ReqTag, AluBusW, AluZero, RespReady,
        input  ReqReady, AluBusA, AluBusB, AluCtrl, RespValid, RespData, RespZero, RespTag, RespErr
    );
    modport slave (
        input  ReqValid, ReqOp, ReqA, ReqB, ReqImm16, ReqHw, ReqTag, AluBusW, AluZero, RespReady,
        output ReqReady, AluBusA, AluBusB, AluCtrl, RespValid, RespData, RespZero, RespTag, RespErr
    );
`endif
endinterface

// File: rtl/alu_op_issuer.sv
// One-at-a-time ALU issuer: response ALU_SETTLE_CYCLES+1 edges after accept (1 for illegal ops),
// held until RespReady; no new request accepted until the response handshakes. Option: ALU_ISSUER_OVF_EN.
module alu_op_issuer #(
    parameter int ALU_SETTLE_CYCLES = 1,
    parameter int TAG_W             = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    alu_op_issuer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] SETTLE = 4'(ALU_SETTLE_CYCLES);

    state_t           state;
    logic [3:0]       settle_cnt;
    logic             req_ready;
    logic             resp_valid;
    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [3:0]       alu_ctrl;
    logic [63:0]      resp_data;
    logic             resp_zero;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    logic             op_legal;
    logic [3:0]       enc_ctrl;
    logic [63:0]      enc_a;
    logic [63:0]      enc_b;

    always_comb begin
        op_legal = 1'b1;
        enc_ctrl = 4'b0000;
        enc_a    = bus.ReqA;
        enc_b    = bus.ReqB;
        case (bus.ReqOp)
            3'd0: enc_ctrl = 4'b0000;
            3'd1: enc_ctrl = 4'b0001;
            3'd2: enc_ctrl = 4'b0010;
            3'd3: enc_ctrl = 4'b0110;
            3'd4: begin
                enc_ctrl = 4'b0111;
                enc_a    = '0;
            end
            3'd5: begin
                // MOVZ packs imm16 and halfword select where the ALU's decoder expects them
                enc_ctrl = 4'b1000;
                enc_a    = {41'b0, bus.ReqHw, bus.ReqImm16, 5'b0};
                enc_b    = '0;
            end
            default: op_legal = 1'b0;
        endcase
    end

`ifdef ALU_ISSUER_OVF_EN
    logic resp_ovf;
    logic ovf_next;

    always_comb begin
        ovf_next = 1'b0;
        if (alu_ctrl == 4'b0010)
            ovf_next = (alu_a[63] == alu_b[63]) && (bus.AluBusW[63] != alu_a[63]);
        else if (alu_ctrl == 4'b0110)
            ovf_next = (alu_a[63] != alu_b[63]) && (bus.AluBusW[63] != alu_a[63]);
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            resp_ovf <= 1'b0;
        else if (state == IDLE && bus.ReqValid)
            resp_ovf <= 1'b0;
        else if (state == DRIVE && settle_cnt == 4'd1)
            resp_ovf <= ovf_next;
    end

    assign bus.RespOvf = resp_ovf;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 4'b0000;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ReqValid) begin
                        req_ready <= 1'b0;
                        resp_tag  <= bus.ReqTag;
                        if (op_legal) begin
                            alu_a      <= enc_a;
                            alu_b      <= enc_b;
                            alu_ctrl   <= enc_ctrl;
                            settle_cnt <= SETTLE;
                            state      <= DRIVE;
                        end else begin
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_zero  <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        resp_data  <= bus.AluBusW;
                        resp_zero  <= bus.AluZero;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.RespReady) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ReqReady  = req_ready;
    assign bus.RespValid = resp_valid;
    assign bus.AluBusA   = alu_a;
    assign bus.AluBusB   = alu_b;
    assign bus.AluCtrl   = alu_ctrl;
    assign bus.RespData  = resp_data;
    assign bus.RespZero  = resp_zero;
    assign bus.RespTag   = resp_tag;
    assign bus.RespErr   = resp_err;
endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer with a behavioural ALU attached to its ALU port.
module tb_alu_op_issuer;
    localparam int S = 3;

    logic CLK;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_issuer_if #(.TAG_W(4)) bus ();

    alu_op_issuer #(.ALU_SETTLE_CYCLES(S), .TAG_W(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: decodes the bus encoding itself
    always_comb begin
        case (bus.AluCtrl)
            4'b0000: bus.AluBusW = bus.AluBusA & bus.AluBusB;
            4'b0001: bus.AluBusW = bus.AluBusA | bus.AluBusB;
            4'b0010: bus.AluBusW = bus.AluBusA + bus.AluBusB;
            4'b0110: bus.AluBusW = bus.AluBusA - bus.AluBusB;
            4'b0111: bus.AluBusW = bus.AluBusB;
            4'b1000: bus.AluBusW = {48'b0, bus.AluBusA[20:5]} << (16 * bus.AluBusA[22:21]);
            default: bus.AluBusW = 64'b0;
        endcase
        bus.AluZero = (bus.AluBusW == 64'b0);
    end

    // Reference model: what the spec says each request should produce
    logic [3:0]  m_ctrl;
    logic [63:0] m_a, m_b;

    function automatic logic f_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    function automatic logic [3:0] f_ctrl(input logic [2:0] op);
        case (op)
            3'd0: return 4'b0000;
            3'd1: return 4'b0001;
            3'd2: return 4'b0010;
            3'd3: return 4'b0110;
            3'd4: return 4'b0111;
            3'd5: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [63:0] f_busa(input logic [2:0] op, input logic [63:0] a,
                                           input logic [15:0] imm, input logic [1:0] hw);
        if (op == 3'd5) return (64'(imm) * 64'd32) + (64'(hw) * 64'h20_0000);
        if (op == 3'd4) return 64'b0;
        return a;
    endfunction

    function automatic logic [63:0] f_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                          input logic [15:0] imm, input logic [1:0] hw);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return b;
            3'd5: return 64'(imm) << (16 * hw);
            default: return 64'b0;
        endcase
    endfunction

    function automatic logic f_ovf(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] s;
        s = 65'sd0;
        if (op == 3'd2) s = $signed({a[63], a}) + $signed({b[63], b});
        else if (op == 3'd3) s = $signed({a[63], a}) - $signed({b[63], b});
        return s[64] != s[63];
    endfunction

    // Observations from the driver task
    int          o_lat;
    logic [3:0]  o_ctrl;
    logic [63:0] o_a, o_b, o_data;
    logic        o_zero, o_err, o_ovf, o_hold_ok, o_stable_ok, o_rv_after, o_rr_after;
    logic [3:0]  o_tag;

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [15:0] imm, input logic [1:0] hw, input logic [3:0] tag, input int bp);
        @(negedge CLK);
        bus.ReqOp = op; bus.ReqA = a; bus.ReqB = b; bus.ReqImm16 = imm; bus.ReqHw = hw; bus.ReqTag = tag;
        bus.ReqValid = 1'b1;
        @(posedge CLK);
        o_lat = -1; o_hold_ok = 1'b1; o_stable_ok = 1'b1; o_ovf = 1'b0;
        o_rv_after = 1'bx; o_rr_after = 1'bx;
        @(negedge CLK);
        bus.ReqValid = 1'b0;
        bus.ReqOp = 3'($urandom); bus.ReqA = {$urandom, $urandom}; bus.ReqB = {$urandom, $urandom};
        bus.ReqTag = 4'($urandom);
        o_ctrl = bus.AluCtrl; o_a = bus.AluBusA; o_b = bus.AluBusB;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge CLK);
            if (bus.RespValid === 1'b1) begin
                o_lat = k;
                break;
            end
            if (bus.ReqReady !== 1'b0 || bus.AluCtrl !== o_ctrl || bus.AluBusA !== o_a || bus.AluBusB !== o_b)
                o_hold_ok = 1'b0;
        end
        if (o_lat < 0) return;
        o_data = bus.RespData; o_zero = bus.RespZero; o_tag = bus.RespTag; o_err = bus.RespErr;
`ifdef ALU_ISSUER_OVF_EN
        o_ovf = bus.RespOvf;
`endif
        repeat (bp) begin
            @(negedge CLK);
            if (bus.RespValid !== 1'b1 || bus.RespData !== o_data || bus.RespZero !== o_zero ||
                bus.RespTag !== o_tag || bus.RespErr !== o_err || bus.ReqReady !== 1'b0 ||
                bus.AluCtrl !== o_ctrl || bus.AluBusA !== o_a)
                o_stable_ok = 1'b0;
        end
        bus.RespReady = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.RespReady = 1'b0;
        o_rv_after = bus.RespValid;
        o_rr_after = bus.ReqReady;
        if (bus.AluCtrl !== o_ctrl || bus.AluBusA !== o_a || bus.AluBusB !== o_b) o_stable_ok = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        m_ctrl = 4'b0; m_a = 64'b0; m_b = 64'b0;
        n_checks++; if (bus.ReqReady !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.ReqReady); end
        n_checks++; if (bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.RespValid); end
        n_checks++; if (bus.AluCtrl !== 4'b0) begin n_fail++; $display("FAIL reset_alu_ctrl: got %b want 0000", bus.AluCtrl); end
        n_checks++;
        if (bus.AluBusA !== 64'b0 || bus.AluBusB !== 64'b0 || bus.RespData !== 64'b0 || bus.RespZero !== 1'b0 ||
            bus.RespTag !== 4'b0 || bus.RespErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: A=%h B=%h D=%h Z=%b T=%h E=%b want all 0",
                     bus.AluBusA, bus.AluBusB, bus.RespData, bus.RespZero, bus.RespTag, bus.RespErr);
        end
`ifdef ALU_ISSUER_OVF_EN
        n_checks++; if (bus.RespOvf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.RespOvf); end
`endif
    endtask

    task automatic test_add;
        issue(3'd2, 64'd5, 64'd7, 16'h0, 2'd0, 4'd3, 0);
        m_ctrl = 4'b0010; m_a = 64'd5; m_b = 64'd7;
        n_checks++; if (o_ctrl !== 4'b0010 || o_a !== 64'd5 || o_b !== 64'd7) begin n_fail++; $display("FAIL add_bus: ctrl=%b A=%h B=%h want 0010/5/7", o_ctrl, o_a, o_b); end
        n_checks++; if (o_lat !== S + 1) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", o_lat, S + 1); end
        n_checks++; if (o_data !== 64'd12 || o_zero !== 1'b0 || o_tag !== 4'd3 || o_err !== 1'b0) begin n_fail++; $display("FAIL add_resp: D=%h Z=%b T=%h E=%b want 12/0/3/0", o_data, o_zero, o_tag, o_err); end
        n_checks++; if (o_hold_ok !== 1'b1) begin n_fail++; $display("FAIL add_hold: got %b want 1", o_hold_ok); end
    endtask

    task automatic test_sub_backpressure;
        issue(3'd3, 64'h1234, 64'h1234, 16'h0, 2'd0, 4'd6, 4);
        m_ctrl = 4'b0110; m_a = 64'h1234; m_b = 64'h1234;
        n_checks++; if (o_data !== 64'd0 || o_zero !== 1'b1 || o_tag !== 4'd6) begin n_fail++; $display("FAIL sub_resp: D=%h Z=%b T=%h want 0/1/6", o_data, o_zero, o_tag); end
        n_checks++; if (o_stable_ok !== 1'b1) begin n_fail++; $display("FAIL sub_stable: got %b want 1", o_stable_ok); end
        n_checks++; if (o_rv_after !== 1'b0 || o_rr_after !== 1'b1) begin n_fail++; $display("FAIL sub_release: RespValid=%b ReqReady=%b want 0/1", o_rv_after, o_rr_after); end
    endtask

    task automatic test_movz;
        logic [63:0] exp_a;
        exp_a = f_busa(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 16'hBEEF, 2'd2);
        issue(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hBEEF, 2'd2, 4'd1, 1);
        m_ctrl = 4'b1000; m_a = exp_a; m_b = 64'b0;
        n_checks++; if (o_ctrl !== 4'b1000 || o_a !== exp_a || o_b !== 64'b0) begin n_fail++; $display("FAIL movz_bus: ctrl=%b A=%h B=%h want 1000/%h/0", o_ctrl, o_a, o_b, exp_a); end
        n_checks++; if (o_data !== 64'h0000_BEEF_0000_0000 || o_err !== 1'b0) begin n_fail++; $display("FAIL movz_resp: D=%h E=%b want 0000beef00000000/0", o_data, o_err); end
    endtask

    task automatic test_illegal;
        issue(3'd7, 64'h55, 64'h66, 16'h0, 2'd0, 4'd9, 0);
        n_checks++; if (o_ctrl !== m_ctrl || o_a !== m_a || o_b !== m_b) begin n_fail++; $display("FAIL illegal_bus: ctrl=%b A=%h want %b/%h unchanged", o_ctrl, o_a, m_ctrl, m_a); end
        n_checks++; if (o_lat !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d want 1", o_lat); end
        n_checks++; if (o_err !== 1'b1 || o_data !== 64'b0 || o_zero !== 1'b0 || o_tag !== 4'd9) begin n_fail++; $display("FAIL illegal_resp: E=%b D=%h Z=%b T=%h want 1/0/0/9", o_err, o_data, o_zero, o_tag); end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [63:0] a, b, res;
        logic [15:0] imm;
        logic [1:0]  hw;
        logic [3:0]  tag;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if (i % 9 == 4) b = a;
            imm = 16'($urandom); hw = 2'($urandom); tag = 4'($urandom);
            issue(op, a, b, imm, hw, tag, $urandom_range(0, 3));
            if (f_legal(op)) begin
                m_ctrl = f_ctrl(op); m_a = f_busa(op, a, imm, hw); m_b = (op == 3'd5) ? 64'b0 : b;
            end
            res = f_res(op, a, b, imm, hw);
            n_checks++; if (o_ctrl !== m_ctrl || o_a !== m_a || o_b !== m_b) begin n_fail++; $display("FAIL rand_bus[%0d]: op=%0d ctrl=%b A=%h B=%h want %b/%h/%h", i, op, o_ctrl, o_a, o_b, m_ctrl, m_a, m_b); end
            n_checks++; if (o_lat !== (f_legal(op) ? S + 1 : 1)) begin n_fail++; $display("FAIL rand_latency[%0d]: op=%0d got %0d", i, op, o_lat); end
            n_checks++;
            if (o_data !== res || o_zero !== (f_legal(op) && res == 64'b0) || o_tag !== tag || o_err !== !f_legal(op)) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: op=%0d D=%h Z=%b T=%h E=%b want D=%h T=%h", i, op, o_data, o_zero, o_tag, o_err, res, tag);
            end
            n_checks++; if (o_hold_ok !== 1'b1 || o_stable_ok !== 1'b1 || o_rv_after !== 1'b0 || o_rr_after !== 1'b1) begin n_fail++; $display("FAIL rand_flow[%0d]: hold=%b stable=%b rv=%b rr=%b", i, o_hold_ok, o_stable_ok, o_rv_after, o_rr_after); end
`ifdef ALU_ISSUER_OVF_EN
            n_checks++; if (o_ovf !== (f_legal(op) && f_ovf(op, a, b))) begin n_fail++; $display("FAIL rand_ovf[%0d]: op=%0d got %b", i, op, o_ovf); end
`endif
        end
    endtask

    task automatic test_back_to_back;
        int acc[$];
        int resp_cnt;
        @(negedge CLK);
        bus.ReqOp = 3'd1; bus.ReqA = 64'hF0; bus.ReqB = 64'h0F; bus.ReqTag = 4'd2;
        bus.ReqValid = 1'b1; bus.RespReady = 1'b1;
        resp_cnt = 0;
        for (int c = 0; c < 60 && acc.size() < 4; c++) begin
            if (bus.ReqReady === 1'b1) acc.push_back(c);
            if (bus.RespValid === 1'b1) begin
                resp_cnt++;
                n_checks++; if (bus.RespData !== 64'hFF) begin n_fail++; $display("FAIL b2b_data: got %h want ff", bus.RespData); end
            end
            @(negedge CLK);
        end
        bus.ReqValid = 1'b0;
        m_ctrl = 4'b0001; m_a = 64'hF0; m_b = 64'h0F;
        n_checks++;
        if (acc.size() < 4) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d accepts want 4", acc.size());
        end else if (acc[1] - acc[0] != S + 2 || acc[3] - acc[2] != S + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d/%0d want %0d", acc[1] - acc[0], acc[3] - acc[2], S + 2);
        end
        n_checks++; if (resp_cnt != 3) begin n_fail++; $display("FAIL b2b_resp_count: got %0d want 3", resp_cnt); end
        repeat (S + 3) @(negedge CLK);
        bus.RespReady = 1'b0;
        n_checks++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: ReqReady=%b RespValid=%b want 1/0", bus.ReqReady, bus.RespValid); end
    endtask

    task automatic test_reset_in_drive;
        logic seen;
        @(negedge CLK);
        bus.ReqOp = 3'd2; bus.ReqA = 64'd100; bus.ReqB = 64'd1; bus.ReqTag = 4'd5; bus.ReqValid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.ReqValid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        m_ctrl = 4'b0; m_a = 64'b0; m_b = 64'b0;
        n_checks++; if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin n_fail++; $display("FAIL rst_drive_flags: ReqReady=%b RespValid=%b want 1/0", bus.ReqReady, bus.RespValid); end
        n_checks++; if (bus.AluCtrl !== 4'b0 || bus.AluBusA !== 64'b0 || bus.RespTag !== 4'b0) begin n_fail++; $display("FAIL rst_drive_outputs: ctrl=%b A=%h T=%h want 0", bus.AluCtrl, bus.AluBusA, bus.RespTag); end
        seen = 1'b0;
        bus.RespReady = 1'b1;
        repeat (S + 6) begin
            @(negedge CLK);
            if (bus.RespValid !== 1'b0) seen = 1'b1;
        end
        bus.RespReady = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_drive_no_resp: RespValid seen=%b want 0", seen); end
    endtask

`ifdef ALU_ISSUER_OVF_EN
    task automatic test_ovf;
        issue(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 16'h0, 2'd0, 4'd4, 0);
        n_checks++; if (o_ovf !== 1'b1 || o_data !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_add: ovf=%b D=%h want 1/8000000000000000", o_ovf, o_data); end
        issue(3'd3, 64'h8000_0000_0000_0000, 64'd1, 16'h0, 2'd0, 4'd4, 0);
        n_checks++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sub: got %b want 1", o_ovf); end
        issue(3'd2, 64'd1, 64'd1, 16'h0, 2'd0, 4'd4, 0);
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none: got %b want 0", o_ovf); end
        issue(3'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 16'h0, 2'd0, 4'd4, 0);
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_illegal: got %b want 0", o_ovf); end
        m_ctrl = 4'b0010; m_a = 64'd1; m_b = 64'd1;
    endtask
`endif

    initial begin
        Reset = 1'b1;
        bus.ReqValid = 1'b0; bus.ReqOp = 3'd0; bus.ReqA = 64'b0; bus.ReqB = 64'b0;
        bus.ReqImm16 = 16'b0; bus.ReqHw = 2'b0; bus.ReqTag = 4'b0; bus.RespReady = 1'b0;
        test_reset;
        test_add;
        test_sub_backpressure;
        test_movz;
        test_illegal;
        test_random;
        test_back_to_back;
        test_reset_in_drive;
`ifdef ALU_ISSUER_OVF_EN
        test_ovf;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
